// File: rtl/coef_loader.sv
// coef_loader -- coefficient loader for the FIR equalizer.
//
// Accepts a serial burst of signed coefficient words over a valid/ready
// handshake, assembles them in a shadow bank and copies the shadow bank to
// the active bank (`coef`) only on a sample boundary, so the filter never
// sees a half-updated tap set.
//
// Optional build macro:
//   COEF_SYM_EN  symmetric (linear-phase) load: (NTAP+1)/2 words per burst,
//                word i fills tap i and its mirror tap NTAP-1-i.
//                Undefined: NTAP words per burst, word i fills tap i.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   cin_valid/ready  coefficient word handshake
//   cin_data         signed coefficient word (W bits)
//   cin_last         last word of a load burst
//   sample_tick      one-cycle pulse at each filter sample boundary
//   coef[NTAP]       active coefficient bank (registered)
//   busy             high whenever a burst is in progress or pending
//   done             one-cycle pulse after the shadow bank is committed
//   err              one-cycle pulse on a malformed burst
module coef_loader #(
    parameter int NTAP = 15,
    parameter int W    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cin_valid,
    input  logic [W-1:0] cin_data,
    input  logic         cin_last,
    output logic         cin_ready,
    input  logic         sample_tick,
    output logic [W-1:0] coef [NTAP],
    output logic         busy,
    output logic         done,
    output logic         err
);

`ifdef COEF_SYM_EN
    localparam int NLOAD = (NTAP + 1) / 2;
    localparam bit SYM   = 1'b1;
`else
    localparam int NLOAD = NTAP;
    localparam bit SYM   = 1'b0;
`endif

    // idx must be able to hold any tap number for the mirror compare
    localparam int            IW       = $clog2(NTAP + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NLOAD - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, PEND} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [W-1:0]    shadow [NTAP];
    logic [NTAP-1:0] shd_we;
    logic            beat;
    logic            commit;
    logic            err_nxt;

    assign beat = cin_valid && cin_ready;

    // idx is zero whenever the FSM sits in IDLE (every path into IDLE
    // clears it), so IDLE and LOAD share the same beat handling.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        err_nxt   = 1'b0;
        commit    = 1'b0;
        shd_we    = '0;
        case (state)
            IDLE, LOAD: begin
                if (beat) begin
                    for (int i = 0; i < NTAP; i++) begin
                        if (idx == IW'(i) || (SYM && idx == IW'(NTAP - 1 - i)))
                            shd_we[i] = 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        idx_nxt = '0;
                        if (cin_last) begin
                            state_nxt = PEND;
                        end else begin
                            // too long: flag once, swallow the rest quietly
                            err_nxt   = 1'b1;
                            state_nxt = DRAIN;
                        end
                    end else if (cin_last) begin
                        // too short: drop it; the partial shadow is never
                        // committed and the next good burst rewrites all taps
                        err_nxt   = 1'b1;
                        idx_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = LOAD;
                    end
                end
            end
            DRAIN: begin
                if (beat && cin_last)
                    state_nxt = IDLE;
            end
            PEND: begin
                if (sample_tick) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            cin_ready <= 1'b1;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            err       <= err_nxt;
            done      <= commit;
            // status flags are registered from the next state so they line
            // up with the state register without any output decode logic
            busy      <= (state_nxt != IDLE);
            cin_ready <= (state_nxt != PEND);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAP; i++) begin
                shadow[i] <= '0;
                coef[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NTAP; i++) begin
                if (shd_we[i])
                    shadow[i] <= cin_data;
                if (commit)
                    coef[i] <= shadow[i];
            end
        end
    end

endmodule

// File: tb/tb_coef_loader.sv
// Self-checking bench for coef_loader. Each burst's outcome (commit, error
// position, resulting bank) is predicted from the burst length and the
// loader's word-count rule; the active bank is tracked as a plain array.
module tb_coef_loader;
    localparam int NTAP = 15;
    localparam int W    = 16;
`ifdef COEF_SYM_EN
    localparam int NLOAD = (NTAP + 1) / 2;
`else
    localparam int NLOAD = NTAP;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cin_valid = 1'b0;
    logic [W-1:0] cin_data = '0;
    logic         cin_last = 1'b0;
    logic         sample_tick = 1'b0;
    logic         cin_ready, busy, done, err;
    logic [W-1:0] coef [NTAP];

    int n_chk = 0;
    int n_fail = 0;

    logic [W-1:0] wbuf [64];
    logic [W-1:0] exp_coef [NTAP];
    int taps [NTAP] = '{338, 533, 1080, 1872, 2754, 3550, 4102, 4300,
                        4102, 3550, 2754, 1872, 1080, 533, 338};

    always #5 clk = ~clk;

    coef_loader #(.NTAP(NTAP), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cin_valid(cin_valid), .cin_data(cin_data), .cin_last(cin_last),
        .cin_ready(cin_ready), .sample_tick(sample_tick),
        .coef(coef), .busy(busy), .done(done), .err(err)
    );

    // Drive one burst of last_at words from wbuf (cin_last on word last_at),
    // optionally with idle gaps, then handle the tick / reset phase.
    task automatic run_burst(input string name, input int last_at, input int gap_max,
                             input int tick_wait, input bit tick_on_last, input bit abort_pend);
        logic [W-1:0] bank [NTAP];
        bit commit;
        int err_at;
        int bad;
        commit = (last_at == NLOAD);
        err_at = (last_at < NLOAD) ? last_at : ((last_at > NLOAD) ? NLOAD : 0);
        for (int i = 0; i < NTAP; i++) bank[i] = '0;
        for (int i = 0; i < NLOAD; i++) begin
            bank[i] = wbuf[i];
`ifdef COEF_SYM_EN
            bank[NTAP-1-i] = wbuf[i];
`endif
        end

        for (int b = 1; b <= last_at; b++) begin
            repeat ($urandom_range(0, gap_max)) begin
                cin_valid   = 1'b0;
                sample_tick = 1'($urandom_range(0, 1));
                @(negedge clk);
                sample_tick = 1'b0;
                n_chk++;
                if (err !== 1'b0 || done !== 1'b0 || cin_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s gap: err=%b done=%b ready=%b, want 0 0 1", name, err, done, cin_ready);
                end
            end
            cin_valid   = 1'b1;
            cin_data    = wbuf[b-1];
            cin_last    = (b == last_at);
            sample_tick = tick_on_last && (b == last_at);
            @(negedge clk);
            cin_valid = 1'b0; cin_last = 1'b0; sample_tick = 1'b0;
            n_chk++;
            if (err !== (b == err_at)) begin
                n_fail++;
                $display("FAIL %s err after beat %0d: got %b want %b", name, b, err, (b == err_at));
            end
            n_chk++;
            if (busy !== !(b == last_at && !commit)) begin
                n_fail++;
                $display("FAIL %s busy after beat %0d: got %b want %b", name, b, busy, !(b == last_at && !commit));
            end
            n_chk++;
            if (cin_ready !== !(b == last_at && commit) || done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s ready/done after beat %0d: got %b/%b want %b/0", name, b, cin_ready, done,
                         !(b == last_at && commit));
            end
        end

        if (commit && abort_pend) begin
            repeat (2) @(negedge clk);
            rst_n = 1'b0;
            #1;
            for (int i = 0; i < NTAP; i++) exp_coef[i] = '0;
            bad = -1;
            for (int i = 0; i < NTAP; i++) if (coef[i] !== exp_coef[i]) bad = i;
            n_chk++;
            if (bad >= 0 || busy !== 1'b0 || cin_ready !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s reset in pend: bad tap %0d busy=%b ready=%b done=%b, want -1 0 1 0",
                         name, bad, busy, cin_ready, done);
            end
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            commit = 1'b0;  // shadow is gone: the following tick must do nothing
        end else if (commit) begin
            for (int c = 0; c < tick_wait; c++) begin
                @(negedge clk);
                bad = -1;
                for (int i = 0; i < NTAP; i++) if (coef[i] !== exp_coef[i]) bad = i;
                n_chk++;
                if (bad >= 0 || cin_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s pending cycle %0d: bad tap %0d ready=%b done=%b busy=%b, want -1 0 0 1",
                             name, c, bad, cin_ready, done, busy);
                end
            end
        end

        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        if (commit) for (int i = 0; i < NTAP; i++) exp_coef[i] = bank[i];
        bad = -1;
        for (int i = 0; i < NTAP; i++) if (coef[i] !== exp_coef[i]) bad = i;
        n_chk++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s coef[%0d] after tick: got %0d want %0d", name, bad,
                     $signed(coef[bad]), $signed(exp_coef[bad]));
        end
        n_chk++;
        if (done !== commit || busy !== 1'b0 || cin_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s after tick: done=%b busy=%b ready=%b, want %b 0 1", name, done, busy, cin_ready, commit);
        end
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        bad = -1;
        for (int i = 0; i < NTAP; i++) if (coef[i] !== '0) bad = i;
        n_chk++;
        if (bad >= 0 || cin_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: bad tap %0d ready=%b busy=%b done=%b err=%b, want -1 1 0 0 0",
                     bad, cin_ready, busy, done, err);
        end
        rst_n = 1'b1;
        for (int i = 0; i < NTAP; i++) exp_coef[i] = '0;
        @(negedge clk);
    endtask

    task automatic fill_taps();
        for (int i = 0; i < 64; i++) wbuf[i] = W'(taps[i % NTAP]);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) wbuf[i] = W'($urandom);
    endtask

    task automatic test_early_last();
        fill_taps();
        run_burst("early_last", 6, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_full_load();
        fill_taps();
        run_burst("full_load", NLOAD, 0, 5, 1'b0, 1'b0);
    endtask

    task automatic test_missing_last();
        fill_random();
        run_burst("missing_last", NLOAD + 2, 0, 0, 1'b0, 1'b0);
`ifdef COEF_SYM_EN
        run_burst("sym_last_9", NLOAD + 1, 0, 0, 1'b0, 1'b0);
`endif
    endtask

    task automatic test_tick_coincident();
        fill_random();
        run_burst("tick_coincident", NLOAD, 0, 8, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        fill_random();
        run_burst("b2b_first", NLOAD, 0, 0, 1'b0, 1'b0);
        fill_random();
        run_burst("b2b_second", NLOAD, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_in_pend();
        fill_taps();
        run_burst("reset_in_pend", NLOAD, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            fill_random();
            run_burst("random", NLOAD - 2 + int'($urandom_range(0, 4)), 2,
                      int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_early_last();
        test_full_load();
        test_missing_last();
        test_tick_coincident();
        test_back_to_back();
        test_reset_in_pend();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/coef_loader.md
# coef_loader

Coefficient loader for the FIR equalizer: accepts a serial stream of signed coefficient words over a valid/ready handshake, assembles them in a shadow bank, and drives the filter's parallel `coef` array. The shadow bank is committed to the active bank only on a filter sample boundary (`sample_tick`), so `filter` never sees a partially updated tap set. It sits directly upstream of `filter` and is driven by the host/config path.

## Interface
- `NTAP`, 15: number of filter taps / active coefficients.
- `W`, 16: coefficient width, two's complement.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `cin_valid` input 1: coefficient word valid.
- `cin_data` input W: signed coefficient word.
- `cin_last` input 1: marks final word of a load burst.
- `cin_ready` output 1: loader accepts a word this cycle.
- `sample_tick` input 1: one-cycle pulse at each filter sample boundary.
- `coef` output NTAP x W (unpacked array, index 0..NTAP-1): active coefficient bank, connects to `filter.coef`.
- `busy` output 1: high in LOAD, DRAIN or PEND.
- `done` output 1: one-cycle pulse after a commit.
- `err` output 1: one-cycle pulse on a malformed burst.

## Operation
- Beat = cycle with `cin_valid && cin_ready`. Word index `idx` counts beats within a burst, 0-based; `NLOAD` = words per burst (see Configuration).
- States: IDLE, LOAD, DRAIN, PEND.
- IDLE: `cin_ready`=1. A beat writes shadow[0], `idx`←1, goes to LOAD (or, if `NLOAD`=1 and `cin_last`, to PEND).
- LOAD: `cin_ready`=1. Each beat writes shadow[`idx`].
  - `cin_last` on `idx`=`NLOAD`-1 → PEND.
  - `cin_last` on `idx`<`NLOAD`-1 → `err` pulse, → IDLE, shadow discarded (active bank untouched).
  - no `cin_last` on `idx`=`NLOAD`-1 → `err` pulse, → DRAIN.
- DRAIN: `cin_ready`=1, beats discarded; beat with `cin_last` → IDLE. No further `err` pulse.
- PEND: `cin_ready`=0. `sample_tick`=1 → active bank ← shadow bank, `done` pulse, → IDLE.
- `sample_tick` in IDLE/LOAD/DRAIN is ignored.
- Shadow words are stored unmodified (no scaling, no saturation); `coef` is a pure register output, no combinational path from inputs.
- `busy` is registered state decode: 0 only in IDLE.

## Timing
- Reset (async assert, sync release): state IDLE, `idx`=0, all `coef[i]`=0, all shadow=0, `cin_ready`=1, `busy`=0, `done`=0, `err`=0.
- Final beat accepted at edge k → PEND from k; `cin_ready` low from k.
- `sample_tick` sampled high at edge m>k → `coef` takes new values at edge m; `done`=1 for cycle m..m+1; `cin_ready`=1 from m.
- `sample_tick` high at edge k itself (same cycle as final beat) does not commit; commit waits for the next tick.
- `err` is high for exactly one cycle following the offending beat's edge.
- Reset mid-burst or in PEND: pending shadow discarded, active bank cleared to zero.
- Back-to-back bursts: new burst may start in the cycle after commit.

## Configuration
- `COEF_SYM_EN` defined: symmetric (linear-phase) load. `NLOAD` = (`NTAP`+1)/2; beat `idx`=i writes shadow[i] and shadow[`NTAP`-1-i] (centre tap written once when `NTAP` odd).
- `COEF_SYM_EN` undefined: `NLOAD` = `NTAP`; each beat writes shadow[`idx`] only.

## Test plan
- Full load (macro off): 15 beats 338,533,1080,1872,2754,3550,4102,4300,4102,3550,2754,1872,1080,533,338 with `cin_last` on beat 15, tick 5 cycles later → `coef` unchanged until tick edge, then matches exactly; `done` one pulse; `cin_ready`=0 between last beat and tick.
- Early last: `cin_last` on beat 6 → `err` one pulse, state IDLE, `coef` unchanged (all 0 after reset), subsequent tick gives no `done`.
- Missing last: 17 beats, `cin_last` on beat 17 → `err` pulse after beat 15, beats 16-17 absorbed, `busy` drops after beat 17, no commit.
- Tick coincident with final beat, then next tick 8 cycles later → commit only at second tick.
- Reset pulse in PEND after a valid 15-word load → all `coef`=0, `busy`=0, no `done`.
- `COEF_SYM_EN`: 8 beats 338,533,1080,1872,2754,3550,4102,4300 + tick → `coef[0..14]` = full symmetric 15-tap set above; `cin_last` on beat 9 → `err`.
